ov5640_cfg_seq: RTL

- Power-up configuration sequencer for the OV5640 camera.
- Walks an external register table (synchronous ROM of {reg_addr16, data8} entries) and issues one SCCB write per entry through the existing IIC master engine (start / wdata / busy / riic_data handshake).
- Optionally reads each register back and counts mismatches.
- Honours in-table delay entries.
- Sits between the system top and the IIC master; cfg_done gates the downstream capture/SDRAM path.

---
 rtl/ov5640_cfg_seq_if.sv | 21 ++
 rtl/ov5640_cfg_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_cfg_seq_if.sv
// Handshake bundle between the OV5640 configuration sequencer and the IIC master engine.
interface ov5640_cfg_seq_if;
   logic        iic_start;
   logic [31:0] iic_wdata;
   logic [7:0]  iic_rdata;
   logic        iic_busy;

   modport master (
      output iic_start,
      output iic_wdata,
      input  iic_rdata,
      input  iic_busy
   );

   modport slave (
      input  iic_start,
      input  iic_wdata,
      output iic_rdata,
      output iic_busy
   );
endinterface

// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up configuration sequencer: walks a {reg_addr16, data8} table held in a
// synchronous ROM, issues one SCCB write per entry through the IIC master, optionally
// reads each register back, honours 0xFFFF delay entries and reports errors.
module ov5640_cfg_seq #(
   parameter int unsigned TBL_DEPTH = 252,
   parameter int unsigned TBL_AW    = 8,
   parameter logic [6:0]  DEV_ID    = 7'h3C,
   parameter int unsigned PWR_DLY   = 1_000_000,
   parameter int unsigned GAP_DLY   = 500,
   parameter int unsigned DLY_UNIT  = 50_000,
   parameter bit          VERIFY    = 1'b0,
   parameter int unsigned BUSY_TO   = 8
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              cfg_req,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [23:0]       tbl_data,
   ov5640_cfg_seq_if.master  iic,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [7:0]        err_cnt
);

   // One shared down-counter serves every timed state; size it for the longest wait.
   localparam int unsigned DLY_MAX = 255 * DLY_UNIT;
   localparam int unsigned MAX_A   = (PWR_DLY > DLY_MAX) ? PWR_DLY : DLY_MAX;
   localparam int unsigned MAX_B   = (GAP_DLY > BUSY_TO) ? GAP_DLY : BUSY_TO;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic cnt_t ld_val(input int unsigned n);
      return (n == 0) ? '0 : cnt_t'(n - 1);
   endfunction

   localparam cnt_t PWR_LD  = ld_val(PWR_DLY);
   localparam cnt_t GAP_LD  = ld_val(GAP_DLY);
   localparam cnt_t BUSY_LD = ld_val(BUSY_TO);
   localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(TBL_DEPTH - 1);

   typedef enum logic [3:0] {
      S_PWR_WAIT,
      S_FETCH,
      S_LATCH,
      S_DELAY,
      S_WR_START,
      S_WAIT_H,
      S_WAIT_L,
      S_GAP_RD,
      S_RD_START,
      S_CHECK,
      S_NEXT,
      S_DONE
   } state_t;

   state_t            state_q;
   cnt_t              cnt_q;
   logic [TBL_AW-1:0] idx_q;
   logic [TBL_AW-1:0] tbl_addr_q;
   logic              start_q;
   logic [31:0]       wdata_q;
   logic [15:0]       reg_addr_q;
   logic [7:0]        reg_data_q;
   logic              rd_phase_q;
   logic              cfg_busy_q;
   logic              cfg_done_q;
   logic              cfg_err_q;
   logic [7:0]        err_cnt_q;
   logic [7:0]        err_cnt_d;
   cnt_t              dly_prod;

   // Saturating error-count increment and delay-entry length from the ROM word.
   always_comb begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      dly_prod  = cnt_t'(tbl_data[7:0]) * cnt_t'(DLY_UNIT);
   end

   // Sequencer FSM; every output is registered here.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q    <= S_PWR_WAIT;
         cnt_q      <= PWR_LD;
         idx_q      <= '0;
         tbl_addr_q <= '0;
         start_q    <= 1'b0;
         wdata_q    <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         rd_phase_q <= 1'b0;
         cfg_busy_q <= 1'b0;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_PWR_WAIT: begin
               cfg_busy_q <= 1'b1;
               if (cnt_q == '0) begin
                  idx_q      <= '0;
                  tbl_addr_q <= '0;
                  state_q    <= S_FETCH;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_FETCH: state_q <= S_LATCH;

            S_LATCH: begin
               reg_addr_q <= tbl_data[23:8];
               reg_data_q <= tbl_data[7:0];
               rd_phase_q <= 1'b0;
               if (tbl_data[23:8] == 16'hFFFF) begin
                  // The LATCH cycle already counts as the first delay cycle.
                  if (dly_prod > cnt_t'(1)) begin
                     cnt_q   <= dly_prod - cnt_t'(2);
                     state_q <= S_DELAY;
                  end else begin
                     cnt_q   <= GAP_LD;
                     state_q <= S_NEXT;
                  end
               end else if (!iic.iic_busy) begin
                  start_q <= 1'b1;
                  wdata_q <= {DEV_ID, 1'b0, tbl_data};
                  state_q <= S_WR_START;
               end
            end

            S_DELAY: begin
               if (cnt_q == '0) begin
                  cnt_q   <= GAP_LD;
                  state_q <= S_NEXT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_WR_START, S_RD_START: begin
               cnt_q   <= BUSY_LD;
               state_q <= S_WAIT_H;
            end

            S_WAIT_H: begin
               if (iic.iic_busy) begin
                  state_q <= S_WAIT_L;
               end else if (cnt_q == '0) begin
                  cfg_err_q <= 1'b1;
                  err_cnt_q <= err_cnt_d;
                  cnt_q     <= GAP_LD;
                  state_q   <= S_NEXT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_WAIT_L: begin
               if (!iic.iic_busy) begin
                  cnt_q <= GAP_LD;
                  if (rd_phase_q) begin
                     state_q <= S_CHECK;
                  end else if (VERIFY) begin
                     state_q <= S_GAP_RD;
                  end else begin
                     state_q <= S_NEXT;
                  end
               end
            end

            S_GAP_RD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!iic.iic_busy) begin
                  start_q    <= 1'b1;
                  wdata_q    <= {DEV_ID, 1'b1, reg_addr_q, 8'h00};
                  rd_phase_q <= 1'b1;
                  state_q    <= S_RD_START;
               end
            end

            S_CHECK: begin
               if (iic.iic_rdata != reg_data_q) begin
                  cfg_err_q <= 1'b1;
                  err_cnt_q <= err_cnt_d;
               end
               cnt_q   <= GAP_LD;
               state_q <= S_NEXT;
            end

            S_NEXT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (idx_q == LAST_IDX) begin
                  cfg_busy_q <= 1'b0;
                  cfg_done_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  idx_q      <= idx_q + 1'b1;
                  tbl_addr_q <= idx_q + 1'b1;
                  state_q    <= S_FETCH;
               end
            end

            S_DONE: begin
               if (cfg_req) begin
                  cfg_done_q <= 1'b0;
                  cfg_err_q  <= 1'b0;
                  err_cnt_q  <= '0;
                  cfg_busy_q <= 1'b1;
                  idx_q      <= '0;
                  tbl_addr_q <= '0;
                  cnt_q      <= PWR_LD;
                  state_q    <= S_PWR_WAIT;
               end
            end

            default: begin
               cnt_q   <= PWR_LD;
               state_q <= S_PWR_WAIT;
            end
         endcase
      end
   end

   assign tbl_addr      = tbl_addr_q;
   assign iic.iic_start = start_q;
   assign iic.iic_wdata = wdata_q;
   assign cfg_busy      = cfg_busy_q;
   assign cfg_done      = cfg_done_q;
   assign cfg_err       = cfg_err_q;
   assign err_cnt       = err_cnt_q;

endmodule
